// File: rtl/uart_peek_pkg.sv
// Shared state encoding and byte constants for the UART peek command sequencer.
// UART_PEEK_CSUM_EN adds the RX_CSUM state used when command/response checksums are enabled.
package uart_peek_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_ADDR,
    S_RX_ID,
`ifdef UART_PEEK_CSUM_EN
    S_RX_CSUM,
`endif
    S_PEEK,
    S_RESP
  } state_t;

  localparam logic [7:0] OP_PEEK   = 8'h01;
  localparam logic [7:0] OP_PING   = 8'h02;

  localparam logic [7:0] RSP_OK    = 8'hA5;
  localparam logic [7:0] RSP_PING  = 8'h5A;
  localparam logic [7:0] RSP_BADOP = 8'hEE;
  localparam logic [7:0] RSP_BADID = 8'hE1;
  localparam logic [7:0] RSP_CSUM  = 8'hEC;

  localparam int RESP_MAX_LEN = 6;

endpackage

// File: rtl/uart_peek_tx_seq.sv
// Response streamer: latches a framed response on load and hands it byte by byte
// to the UART TX valid/ready interface; done marks the cycle of the last transfer.
module uart_peek_tx_seq
  import uart_peek_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [RESP_MAX_LEN-1:0][7:0]  load_buf,
  input  logic [2:0]                    load_len,
  input  logic                          tx_ready,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  output logic                          done
);

  logic [RESP_MAX_LEN-1:0][7:0] resp_q;
  logic [2:0]                   len_q;
  logic [2:0]                   idx;

  assign done = tx_valid && tx_ready && (idx == len_q - 3'd1);

  // tx_data only advances on a completed transfer so the byte stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q   <= '0;
      len_q    <= '0;
      idx      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      resp_q   <= load_buf;
      len_q    <= load_len;
      idx      <= '0;
      tx_data  <= load_buf[0];
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      if (done) begin
        tx_valid <= 1'b0;
      end else begin
        idx     <= idx + 3'd1;
        tx_data <= resp_q[idx + 3'd1];
      end
    end
  end

endmodule

// File: rtl/uart_peek_ctrl.sv
// Parses host PEEK/PING frames from UART RX, issues NoC peek reads and streams framed replies.
// Define UART_PEEK_CSUM_EN to require/append XOR checksum bytes on commands and responses.
module uart_peek_ctrl
  import uart_peek_pkg::*;
#(
  parameter int N_CORES        = 9,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int ID_W           = $clog2(N_CORES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            peek_req,
  output logic [31:0]     peek_addr,
  output logic [ID_W-1:0] peek_id,
  input  logic            peek_ack,
  input  logic [31:0]     peek_rdata,
  output logic            busy,
  output logic            err_pulse
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                       state;
  logic [1:0]                   byte_cnt;
  logic [GAP_W-1:0]             gap;
  logic                         in_rx;
  logic                         timed_out;
  logic                         rsp_load;
  logic [7:0]                   rsp_code;
  logic                         rsp_err;
  logic [RESP_MAX_LEN-1:0][7:0] rsp_buf;
  logic [2:0]                   rsp_len;
  logic                         rsp_done;
  logic                         start_peek;
  logic [7:0]                   id_cand;
`ifdef UART_PEEK_CSUM_EN
  logic [7:0]                   csum;
  logic [7:0]                   id_byte;
  logic [7:0]                   pend_code;
  logic [7:0]                   rsp_xor;
`endif

`ifdef UART_PEEK_CSUM_EN
  assign in_rx   = (state == S_RX_ADDR) || (state == S_RX_ID) || (state == S_RX_CSUM);
  assign id_cand = id_byte;
`else
  assign in_rx   = (state == S_RX_ADDR) || (state == S_RX_ID);
  assign id_cand = rx_data;
`endif
  assign timed_out = in_rx && !rx_valid && (gap == GAP_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err   = (rsp_code == RSP_BADOP) || (rsp_code == RSP_BADID) || (rsp_code == RSP_CSUM);

  // Decide in the accepting cycle whether a response starts or a peek is launched.
  always_comb begin
    rsp_load   = 1'b0;
    rsp_code   = RSP_OK;
    start_peek = 1'b0;
    case (state)
`ifdef UART_PEEK_CSUM_EN
      S_RX_CSUM: if (rx_valid) begin
        if (rx_data != csum) begin
          rsp_load = 1'b1;
          rsp_code = RSP_CSUM;
        end else if (pend_code != RSP_OK) begin
          rsp_load = 1'b1;
          rsp_code = pend_code;
        end else if (32'(id_cand) >= N_CORES) begin
          rsp_load = 1'b1;
          rsp_code = RSP_BADID;
        end else begin
          start_peek = 1'b1;
        end
      end
`else
      S_IDLE: if (rx_valid && rx_data != OP_PEEK) begin
        rsp_load = 1'b1;
        rsp_code = (rx_data == OP_PING) ? RSP_PING : RSP_BADOP;
      end
      S_RX_ID: if (rx_valid) begin
        if (32'(id_cand) >= N_CORES) begin
          rsp_load = 1'b1;
          rsp_code = RSP_BADID;
        end else begin
          start_peek = 1'b1;
        end
      end
`endif
      S_PEEK: if (peek_ack) rsp_load = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rsp_buf    = '0;
    rsp_buf[0] = rsp_code;
    rsp_len    = 3'd1;
    if (rsp_code == RSP_OK) begin
      rsp_buf[1] = peek_rdata[7:0];
      rsp_buf[2] = peek_rdata[15:8];
      rsp_buf[3] = peek_rdata[23:16];
      rsp_buf[4] = peek_rdata[31:24];
      rsp_len    = 3'd5;
    end
`ifdef UART_PEEK_CSUM_EN
    rsp_xor = '0;
    for (int i = 0; i < RESP_MAX_LEN; i++) rsp_xor = rsp_xor ^ rsp_buf[i];
    rsp_buf[rsp_len] = rsp_xor;
    rsp_len          = rsp_len + 3'd1;
`endif
  end

  // Main sequencer; an expired gap counter drops the partial frame without replying.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      byte_cnt  <= '0;
      gap       <= '0;
      busy      <= 1'b0;
      err_pulse <= 1'b0;
      peek_req  <= 1'b0;
      peek_addr <= '0;
      peek_id   <= '0;
`ifdef UART_PEEK_CSUM_EN
      csum      <= '0;
      id_byte   <= '0;
      pend_code <= '0;
`endif
    end else begin
      err_pulse <= rsp_load && rsp_err;
      gap       <= (!in_rx || rx_valid) ? '0 : gap + 1'b1;
      if (rsp_load) begin
        state    <= S_RESP;
        busy     <= 1'b1;
        peek_req <= 1'b0;
      end else if (start_peek) begin
        state    <= S_PEEK;
        busy     <= 1'b1;
        peek_req <= 1'b1;
        peek_id  <= id_cand[ID_W-1:0];
      end else if (timed_out) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        err_pulse <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (rx_valid) begin
            busy     <= 1'b1;
            byte_cnt <= '0;
`ifdef UART_PEEK_CSUM_EN
            csum      <= rx_data;
            pend_code <= (rx_data == OP_PEEK) ? RSP_OK :
                         (rx_data == OP_PING) ? RSP_PING : RSP_BADOP;
            state     <= (rx_data == OP_PEEK) ? S_RX_ADDR : S_RX_CSUM;
`else
            state    <= S_RX_ADDR;
`endif
          end
          S_RX_ADDR: if (rx_valid) begin
            peek_addr[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) state <= S_RX_ID;
`ifdef UART_PEEK_CSUM_EN
            csum <= csum ^ rx_data;
`endif
          end
`ifdef UART_PEEK_CSUM_EN
          S_RX_ID: if (rx_valid) begin
            id_byte <= rx_data;
            csum    <= csum ^ rx_data;
            state   <= S_RX_CSUM;
          end
`endif
          S_RESP: if (rsp_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  uart_peek_tx_seq u_tx_seq (
    .clk      (clk),
    .rst      (rst),
    .load     (rsp_load),
    .load_buf (rsp_buf),
    .load_len (rsp_len),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .done     (rsp_done)
  );

endmodule

// File: tb/tb_uart_peek_ctrl.sv
// Directed bench for uart_peek_ctrl; commands and expected replies gain checksum bytes
// automatically when UART_PEEK_CSUM_EN is defined.
module tb_uart_peek_ctrl;

  localparam int N_CORES = 9;
  localparam int TIMEOUT = 16;
  localparam int ID_W    = $clog2(N_CORES);
`ifdef UART_PEEK_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef logic [7:0] bytes_t[$];

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      rx_data = '0;
  logic            rx_valid = 1'b0;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready = 1'b1;
  logic            peek_req;
  logic [31:0]     peek_addr;
  logic [ID_W-1:0] peek_id;
  logic            peek_ack = 1'b0;
  logic [31:0]     peek_rdata = '0;
  logic            busy;
  logic            err_pulse;

  int         total_cnt = 0;
  int         pass_cnt  = 0;
  logic [7:0] txq[$];
  int         err_cnt   = 0;
  int         hold_viol = 0;
  bit         req_seen  = 1'b0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  uart_peek_ctrl #(.N_CORES(N_CORES), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .peek_req   (peek_req),
    .peek_addr  (peek_addr),
    .peek_id    (peek_id),
    .peek_ack   (peek_ack),
    .peek_rdata (peek_rdata),
    .busy       (busy),
    .err_pulse  (err_pulse)
  );

  always #5 clk = ~clk;

  // Mid-cycle monitor: records transfers, error pulses, requests and backpressure stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (err_pulse) err_cnt++;
      if (peek_req) req_seen = 1'b1;
      if (prev_hold && (tx_valid !== 1'b1 || tx_data !== prev_data)) hold_viol++;
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  function automatic bytes_t frame(input bytes_t b);
    bytes_t     r = b;
    logic [7:0] x = '0;
    if (CSUM) begin
      foreach (b[i]) x = x ^ b[i];
      r.push_back(x);
    end
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input bytes_t b);
    bytes_t f = frame(b);
    foreach (f[i]) send_byte(f[i]);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    total_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL %s_idle: busy=%b required 0 within 200 cycles", name, busy);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total_cnt += 7;
    if (tx_valid !== 1'b0) $display("[TB] FAIL rst_tx_valid: got %b required 0", tx_valid); else pass_cnt++;
    if (peek_req !== 1'b0) $display("[TB] FAIL rst_peek_req: got %b required 0", peek_req); else pass_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b required 0", busy); else pass_cnt++;
    if (err_pulse !== 1'b0) $display("[TB] FAIL rst_err: got %b required 0", err_pulse); else pass_cnt++;
    if (tx_data !== 8'h00) $display("[TB] FAIL rst_tx_data: got %h required 00", tx_data); else pass_cnt++;
    if (peek_addr !== 32'h0) $display("[TB] FAIL rst_addr: got %h required 0", peek_addr); else pass_cnt++;
    if (peek_id !== '0) $display("[TB] FAIL rst_id: got %h required 0", peek_id); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_peek;
    bytes_t exp = frame('{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    int     e0  = err_cnt;
    txq.delete();
    tx_ready = 1'b1;
    send_cmd('{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h03});
    @(negedge clk); #1;
    total_cnt += 3;
    if (peek_req !== 1'b1) $display("[TB] FAIL peek_req_latency: got %b required 1", peek_req); else pass_cnt++;
    if (peek_addr !== 32'h10) $display("[TB] FAIL peek_addr: got %h required 00000010", peek_addr); else pass_cnt++;
    if (peek_id !== ID_W'(3)) $display("[TB] FAIL peek_id: got %0d required 3", peek_id); else pass_cnt++;
    repeat (4) @(posedge clk); #1;
    peek_rdata = 32'hDEADBEEF;
    peek_ack   = 1'b1;
    @(posedge clk); #1;
    peek_ack = 1'b0;
    total_cnt += 3;
    if (peek_req !== 1'b0) $display("[TB] FAIL peek_req_drop: got %b required 0", peek_req); else pass_cnt++;
    if (tx_valid !== 1'b1) $display("[TB] FAIL peek_tx_latency: got %b required 1", tx_valid); else pass_cnt++;
    if (tx_data !== 8'hA5) $display("[TB] FAIL peek_first_byte: got %h required a5", tx_data); else pass_cnt++;
    wait_idle("peek");
    total_cnt++;
    if (txq.size() != exp.size()) $display("[TB] FAIL peek_len: got %0d required %0d", txq.size(), exp.size()); else pass_cnt++;
    foreach (exp[i]) begin
      total_cnt++;
      if (i >= txq.size() || txq[i] !== exp[i]) $display("[TB] FAIL peek_byte%0d: got %h required %h", i, (i < txq.size()) ? txq[i] : 8'hxx, exp[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (err_cnt != e0) $display("[TB] FAIL peek_no_err: got %0d pulses required 0", err_cnt - e0); else pass_cnt++;
  endtask

  task automatic test_ping_backpressure;
    bytes_t exp = frame('{8'h5A});
    txq.delete();
    hold_viol = 0;
    tx_ready  = 1'b1;
    send_cmd('{8'h02});
    for (int n = 0; n < 40 && busy === 1'b1; n++) begin
      tx_ready = ~tx_ready;
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    wait_idle("ping");
    total_cnt += 2;
    if (hold_viol != 0) $display("[TB] FAIL ping_hold_stable: got %0d changes required 0", hold_viol); else pass_cnt++;
    if (txq.size() != exp.size()) $display("[TB] FAIL ping_len: got %0d required %0d", txq.size(), exp.size()); else pass_cnt++;
    foreach (exp[i]) begin
      total_cnt++;
      if (i >= txq.size() || txq[i] !== exp[i]) $display("[TB] FAIL ping_byte%0d: got %h required %h", i, (i < txq.size()) ? txq[i] : 8'hxx, exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_errors;
    bytes_t exp = frame('{8'hEE});
    int     e0  = err_cnt;
    txq.delete();
    send_cmd('{8'h7F});
    wait_idle("badop");
    total_cnt += 2;
    if (txq.size() != exp.size() || txq[0] !== exp[0] || txq[$] !== exp[$])
      $display("[TB] FAIL badop_resp: got %0d bytes first %h required %0d bytes first %h", txq.size(), txq[0], exp.size(), exp[0]);
    else pass_cnt++;
    if (err_cnt - e0 != 1) $display("[TB] FAIL badop_err: got %0d pulses required 1", err_cnt - e0); else pass_cnt++;
    exp = frame('{8'hE1});
    e0  = err_cnt;
    txq.delete();
    req_seen = 1'b0;
    send_cmd('{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h09});
    wait_idle("badid");
    total_cnt += 3;
    if (txq.size() != exp.size() || txq[0] !== exp[0] || txq[$] !== exp[$])
      $display("[TB] FAIL badid_resp: got %0d bytes first %h required %0d bytes first %h", txq.size(), txq[0], exp.size(), exp[0]);
    else pass_cnt++;
    if (req_seen) $display("[TB] FAIL badid_no_req: got 1 required 0"); else pass_cnt++;
    if (err_cnt - e0 != 1) $display("[TB] FAIL badid_err: got %0d pulses required 1", err_cnt - e0); else pass_cnt++;
  endtask

  task automatic test_timeout;
    bytes_t exp = frame('{8'h5A});
    int     e0  = err_cnt;
    txq.delete();
    send_byte(8'h01);
    send_byte(8'h20);
    repeat (15) @(posedge clk);
    @(negedge clk); #1;
    total_cnt++;
    if (busy !== 1'b1) $display("[TB] FAIL timeout_early: busy=%b required 1", busy); else pass_cnt++;
    @(posedge clk);
    @(negedge clk); #1;
    total_cnt += 3;
    if (busy !== 1'b0) $display("[TB] FAIL timeout_idle: busy=%b required 0", busy); else pass_cnt++;
    if (err_pulse !== 1'b1) $display("[TB] FAIL timeout_err: got %b required 1", err_pulse); else pass_cnt++;
    if (txq.size() != 0) $display("[TB] FAIL timeout_no_tx: got %0d bytes required 0", txq.size()); else pass_cnt++;
    @(posedge clk); #1;
    send_cmd('{8'h02});
    wait_idle("timeout_ping");
    total_cnt++;
    if (txq.size() != exp.size() || txq[0] !== 8'h5A)
      $display("[TB] FAIL timeout_ping: got %0d bytes first %h required %0d bytes first 5a", txq.size(), txq[0], exp.size());
    else pass_cnt++;
    // A byte arriving exactly on the expiry cycle must keep the frame alive.
    e0 = err_cnt;
    exp = frame('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00});
    txq.delete();
    send_byte(8'h01);
    send_byte(8'h20);
    repeat (15) @(posedge clk); #1;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h05);
    if (CSUM) send_byte(8'h24);
    @(negedge clk); #1;
    total_cnt += 3;
    if (peek_req !== 1'b1) $display("[TB] FAIL expiry_req: got %b required 1", peek_req); else pass_cnt++;
    if (peek_addr !== 32'h20) $display("[TB] FAIL expiry_addr: got %h required 00000020", peek_addr); else pass_cnt++;
    if (err_cnt != e0) $display("[TB] FAIL expiry_no_err: got %0d pulses required 0", err_cnt - e0); else pass_cnt++;
    @(posedge clk); #1;
    peek_rdata = 32'h0;
    peek_ack   = 1'b1;
    @(posedge clk); #1;
    peek_ack = 1'b0;
    wait_idle("expiry");
    total_cnt++;
    if (txq.size() != exp.size() || txq[0] !== 8'hA5)
      $display("[TB] FAIL expiry_resp: got %0d bytes first %h required %0d bytes first a5", txq.size(), txq[0], exp.size());
    else pass_cnt++;
  endtask

  task automatic test_drop_and_reset;
    int e0 = err_cnt;
    txq.delete();
    tx_ready = 1'b0;
    send_cmd('{8'h01, 8'h40, 8'h00, 8'h00, 8'h00, 8'h01});
    send_byte(8'h02);
    send_byte(8'h7F);
    @(negedge clk); #1;
    total_cnt += 2;
    if (peek_req !== 1'b1) $display("[TB] FAIL drop_req_held: got %b required 1", peek_req); else pass_cnt++;
    if (err_cnt != e0) $display("[TB] FAIL drop_no_err: got %0d pulses required 0", err_cnt - e0); else pass_cnt++;
    @(posedge clk); #1;
    peek_rdata = 32'h11223344;
    peek_ack   = 1'b1;
    @(posedge clk); #1;
    peek_ack = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    tx_ready = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    total_cnt += 2;
    if (tx_valid !== 1'b0) $display("[TB] FAIL rst_resp_valid: got %b required 0", tx_valid); else pass_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL rst_resp_busy: got %b required 0", busy); else pass_cnt++;
    rst      = 1'b0;
    tx_ready = 1'b1;
    repeat (10) @(posedge clk); #1;
    total_cnt += 3;
    if (txq.size() != 2) $display("[TB] FAIL rst_resp_count: got %0d bytes required 2", txq.size()); else pass_cnt++;
    if (txq.size() < 1 || txq[0] !== 8'hA5) $display("[TB] FAIL rst_resp_b0: got %h required a5", (txq.size() > 0) ? txq[0] : 8'hxx); else pass_cnt++;
    if (txq.size() < 2 || txq[1] !== 8'h44) $display("[TB] FAIL rst_resp_b1: got %h required 44", (txq.size() > 1) ? txq[1] : 8'hxx); else pass_cnt++;
  endtask

`ifdef UART_PEEK_CSUM_EN
  task automatic test_csum;
    int e0;
    txq.delete();
    send_byte(8'h02);
    send_byte(8'h02);
    wait_idle("csum_ok");
    total_cnt++;
    if (txq.size() != 2 || txq[0] !== 8'h5A || txq[1] !== 8'h5A)
      $display("[TB] FAIL csum_ping: got %0d bytes %h %h required 2 bytes 5a 5a", txq.size(), txq[0], txq[1]);
    else pass_cnt++;
    e0 = err_cnt;
    txq.delete();
    send_byte(8'h02);
    send_byte(8'h00);
    wait_idle("csum_bad");
    total_cnt += 2;
    if (txq.size() != 2 || txq[0] !== 8'hEC || txq[1] !== 8'hEC)
      $display("[TB] FAIL csum_bad: got %0d bytes %h %h required 2 bytes ec ec", txq.size(), txq[0], txq[1]);
    else pass_cnt++;
    if (err_cnt - e0 != 1) $display("[TB] FAIL csum_err: got %0d pulses required 1", err_cnt - e0); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_peek();
    test_ping_backpressure();
    test_errors();
    test_timeout();
    test_drop_and_reset();
`ifdef UART_PEEK_CSUM_EN
    test_csum();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
